rst_sequencer: RTL and testbench
================================

# rst_sequencer

Reset sequencer directly downstream of the Nexys A7 clock generator. Consumes the PLL-derived 25 MHz clock and its raw reset and releases three reset domains (peripherals, memory controller, core) in a fixed order, with a programmable hold time and inter-stage gaps. It also accepts an optional software reset request and reports the cause of the last reset, so firmware can tell a PLL or board reset from a self-requested one.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in the reset deassertion synchronizer (≥2)
- STRETCH_CYCLES, 16, cycles all domains stay in reset after the synchronized release (≥1)
- STAGE_GAP, 8, cycles between successive domain releases (≥1)

Ports:
- i_clk  input  1  25 MHz system clock
- i_rst  input  1  reset, asynchronous, active-high (PLL-not-locked or board reset)
- i_sw_rst_req  input  1  software reset request, synchronous to i_clk
- o_rst_periph  output  1  peripheral-domain reset, active-high
- o_rst_mem  output  1  memory-domain reset, active-high
- o_rst_core  output  1  core-domain reset, active-high
- o_rst_busy  output  1  high while any domain output is still high
- o_rst_cause  output  2  cause of last reset: 2'b01 hardware, 2'b10 software

## Operation
- i_rst assertion immediately and asynchronously drives the following:
  - all o_rst_* and o_rst_busy to 1
  - o_rst_cause to 2'b01
  - FSM to HOLD and the counter to 0
- i_rst deassertion passes through the SYNC_STAGES synchronizer. It has asynchronous assertion and synchronous deassertion. The FSM advances only while the synchronizer output is low.
- FSM states:
  - HOLD: count STRETCH_CYCLES, then clear o_rst_periph and go to REL_PERIPH with the counter at 0.
  - REL_PERIPH: count STAGE_GAP, then clear o_rst_mem and go to REL_MEM.
  - REL_MEM: count STAGE_GAP, then clear o_rst_core and o_rst_busy and go to RUN.
  - RUN: idle.
- Software reset (see Configuration): i_sw_rst_req sampled high in RUN sets the following at the next edge, after which the sequence replays:
  - all three domain outputs and o_rst_busy to 1
  - o_rst_cause to 2'b10
  - FSM to HOLD with the counter at 0
- i_sw_rst_req is ignored in every state except RUN. The request is level-sensitive in RUN, so a request held high retriggers each time RUN is reached; requesters must pulse it.
- o_rst_cause holds its value until the next reset event.
- Counter width is $clog2(max(STRETCH_CYCLES, STAGE_GAP)+1). The counter saturates and never wraps.
- All outputs are registered, with no combinational path from the inputs.

## Timing
- Edge numbering: edge 1 is the first rising edge after i_rst falls.
- With the defaults, the synchronizer output is low after edge 2.
- Release edges with the defaults:
  - o_rst_periph falls after edge 18
  - o_rst_mem falls after edge 26
  - o_rst_core and o_rst_busy fall after edge 34
- General rule: periph at SYNC_STAGES+STRETCH_CYCLES; each later domain STAGE_GAP edges after the previous one.
- For a software request sampled at edge n: outputs go high after edge n; periph falls at n+STRETCH_CYCLES, mem at n+STRETCH_CYCLES+STAGE_GAP, core at n+STRETCH_CYCLES+2·STAGE_GAP.
- i_rst reasserted mid-sequence, even for one cycle, restarts everything from HOLD with cause 2'b01.
- i_rst always has priority over a simultaneous i_sw_rst_req.

## Configuration
- RST_SEQ_SWRST_EN defined: the i_sw_rst_req path and cause 2'b10 are present as described.
- RST_SEQ_SWRST_EN undefined: i_sw_rst_req is an unused input, RUN is terminal until i_rst, and o_rst_cause is constant 2'b01.

## Structure
- Package rst_seq_pkg holds:
  - the FSM state typedef (HOLD, REL_PERIPH, REL_MEM, RUN)
  - cause constants RST_CAUSE_HW=2'b01 and RST_CAUSE_SW=2'b10
- Sub-module rst_sync: a SYNC_STAGES-deep flop chain with async set from i_rst and synchronous deassert. It is reusable by other domains.

## Test plan
- Power-on: i_rst high for 5 cycles then low → periph falls after edge 18, mem after 26, core and busy after 34, cause 2'b01.
- Async assert: in RUN, raise i_rst between clock edges → all outputs 1 before the next edge; the release sequence repeats.
- Software reset: in RUN, pulse i_sw_rst_req at edge n → outputs 1 after n, periph falls at n+16, mem at n+24, core at n+32, cause 2'b10.
- Ignored request: i_sw_rst_req high during REL_MEM only → release timing unchanged, cause stays 2'b01.
- Mid-sequence glitch: a one-cycle i_rst pulse at edge 22 → HOLD restarts, periph falls 18 edges after the pulse ends, cause 2'b01.
- Macro off: build without RST_SEQ_SWRST_EN and pulse i_sw_rst_req in RUN → no output change, cause 2'b01.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: sequencer FSM states and reset-cause encodings shared by rst_sequencer.
package rst_seq_pkg;
  typedef enum logic [1:0] {HOLD, REL_PERIPH, REL_MEM, RUN} state_e;
  localparam logic [1:0] RST_CAUSE_HW = 2'b01;
  localparam logic [1:0] RST_CAUSE_SW = 2'b10;
endpackage

// File: rtl/rst_sync.sv
// rst_sync: reset synchronizer, asynchronous assertion and synchronous deassertion.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rst
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) sync_q <= '1;
    else sync_q <= {sync_q[STAGES-2:0], 1'b0};
  assign o_rst = sync_q[STAGES-1];
endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: ordered release of periph/mem/core resets with reset-cause reporting.
// Define RST_SEQ_SWRST_EN to enable the software reset request path.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sw_rst_req,
  output logic       o_rst_periph,
  output logic       o_rst_mem,
  output logic       o_rst_core,
  output logic       o_rst_busy,
  output logic [1:0] o_rst_cause
);
  localparam int CNT_MAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic periph_q, periph_d, mem_q, mem_d, core_q, core_d, busy_q;
  logic sync_rst, sw_go;
  rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_rst (sync_rst)
  );
`ifdef RST_SEQ_SWRST_EN
  logic [1:0] cause_q;
  assign sw_go = (state_q == RUN) && i_sw_rst_req;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cause_q <= RST_CAUSE_HW;
    else if (sw_go) cause_q <= RST_CAUSE_SW;
  assign o_rst_cause = cause_q;
`else
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = i_sw_rst_req;
  assign sw_go = 1'b0;
  assign o_rst_cause = RST_CAUSE_HW;
`endif
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    mem_d    = mem_q;
    core_d   = core_q;
    if (sw_go) begin
      state_d  = HOLD;
      cnt_d    = '0;
      periph_d = 1'b1;
      mem_d    = 1'b1;
      core_d   = 1'b1;
    end else if (!sync_rst) begin
      case (state_q)
        HOLD:
          if (cnt_q == STRETCH_LAST) begin
            state_d  = REL_PERIPH;
            cnt_d    = '0;
            periph_d = 1'b0;
          end else cnt_d = cnt_inc;
        REL_PERIPH:
          if (cnt_q == GAP_LAST) begin
            state_d = REL_MEM;
            cnt_d   = '0;
            mem_d   = 1'b0;
          end else cnt_d = cnt_inc;
        REL_MEM:
          if (cnt_q == GAP_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            core_d  = 1'b0;
          end else cnt_d = cnt_inc;
        default: ;
      endcase
    end
  end
  // Busy mirrors the core reset, which is always the last domain to release.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      mem_q    <= 1'b1;
      core_q   <= 1'b1;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      mem_q    <= mem_d;
      core_q   <= core_d;
      busy_q   <= core_d;
    end
  assign o_rst_periph = periph_q;
  assign o_rst_mem    = mem_q;
  assign o_rst_core   = core_q;
  assign o_rst_busy   = busy_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: scenario tasks checked against an edge-count model of the release schedule.
module tb_rst_sequencer;
  localparam int SS = 2, ST = 16, SG = 8;
`ifdef RST_SEQ_SWRST_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, sw = 1'b0;
  logic periph, mem, core, busy;
  logic [1:0] cause;
  logic [5:0] obs;
  int total = 0, bad = 0;
  int k = 0;
  bit sw_mode = 1'b0;
  logic [1:0] cause_m = 2'b01;
  rst_sequencer #(.SYNC_STAGES(SS), .STRETCH_CYCLES(ST), .STAGE_GAP(SG)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sw_rst_req (sw),
    .o_rst_periph (periph),
    .o_rst_mem    (mem),
    .o_rst_core   (core),
    .o_rst_busy   (busy),
    .o_rst_cause  (cause)
  );
  always #20 clk = ~clk;
  assign obs = {periph, mem, core, busy, cause};
  function automatic logic [5:0] exp_vec();
    int b;
    logic p, m, c;
    b = sw_mode ? ST : SS + ST;
    p = k < b;
    m = k < b + SG;
    c = k < b + 2 * SG;
    return {p, m, c, c, cause_m};
  endfunction
  // k counts edges since the last reset event; release edges follow from the schedule offsets.
  always @(posedge clk or posedge rst) begin : model
    logic [5:0] e;
    e = exp_vec();
    if (rst) begin
      k = 0;
      sw_mode = 1'b0;
      cause_m = 2'b01;
    end else if (SW_EN && sw && !e[3]) begin
      k = 0;
      sw_mode = 1'b1;
      cause_m = 2'b10;
    end else k++;
  end
  task automatic test_reset();
    int pf = 0, mf = 0, cf = 0;
    sw = 1'b0;
    #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (obs !== 6'b111101) begin bad++; $display("FAIL reset_state obs=%b exp=%b", obs, 6'b111101); end
    rst = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL poweron edge=%0d obs=%b exp=%b", e, obs, exp_vec()); end
      if (!periph && pf == 0) pf = e;
      if (!mem && mf == 0) mf = e;
      if (!core && cf == 0) cf = e;
    end
    total++;
    if (pf !== 18 || mf !== 26 || cf !== 34)
      begin bad++; $display("FAIL poweron_edges got=%0d/%0d/%0d exp=18/26/34", pf, mf, cf); end
  endtask
  task automatic test_async_assert();
    @(posedge clk); #7 rst = 1'b1; #1;
    total++;
    if (obs !== 6'b111101) begin bad++; $display("FAIL async_assert obs=%b exp=%b", obs, 6'b111101); end
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL async_seq edge=%0d obs=%b exp=%b", e, obs, exp_vec()); end
    end
  endtask
  task automatic test_sw_reset();
    int pf = 0, mf = 0, cf = 0;
    logic [5:0] ex;
    ex = SW_EN ? 6'b111110 : 6'b000001;
    @(negedge clk); sw = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== ex) begin bad++; $display("FAIL sw_assert obs=%b exp=%b", obs, ex); end
    @(negedge clk); sw = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL sw_seq edge=%0d obs=%b exp=%b", e, obs, exp_vec()); end
      if (!periph && pf == 0) pf = e;
      if (!mem && mf == 0) mf = e;
      if (!core && cf == 0) cf = e;
    end
    total++;
    if (SW_EN ? (pf !== ST || mf !== ST + SG || cf !== ST + 2 * SG) : (pf !== 1 || mf !== 1 || cf !== 1))
      begin bad++; $display("FAIL sw_edges got=%0d/%0d/%0d sw_en=%0d", pf, mf, cf, SW_EN); end
    total++;
    if (cause !== (SW_EN ? 2'b10 : 2'b01)) begin bad++; $display("FAIL sw_cause obs=%b sw_en=%0d", cause, SW_EN); end
  endtask
  task automatic test_ignored_req();
    int cf = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL ignored_seq edge=%0d obs=%b exp=%b", e, obs, exp_vec()); end
      if (!core && cf == 0) cf = e;
      sw = (e + 1 > SS + ST + SG) && (e + 1 <= SS + ST + 2 * SG);
    end
    total++;
    if (cf !== 34 || cause !== 2'b01) begin bad++; $display("FAIL ignored_req core_edge=%0d cause=%b exp=34/01", cf, cause); end
  endtask
  task automatic test_glitch();
    int pf = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL glitch_seq edge=%0d obs=%b exp=%b", e, obs, exp_vec()); end
      if (e > 22 && !periph && pf == 0) pf = e;
      if (e == 21) rst = 1'b1;
      if (e == 22) rst = 1'b0;
    end
    total++;
    if (pf !== 22 + SS + ST || cause !== 2'b01) begin bad++; $display("FAIL glitch periph_edge=%0d cause=%b exp=%0d/01", pf, cause, 22 + SS + ST); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 79) == 0);
      sw = ($urandom_range(0, 5) == 0);
      @(posedge clk); #1;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d obs=%b exp=%b", i, obs, exp_vec()); end
    end
    @(negedge clk); rst = 1'b0; sw = 1'b0;
  endtask
  initial begin
    test_reset();
    test_async_assert();
    test_sw_reset();
    test_ignored_req();
    test_glitch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
